// File: rtl/matching_pkg.sv
// Shared types and width helpers for the RO matching controller.
package matching_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    SCAN,
    MATCHED,
    FAIL
  } state_e;

  // Width of the RO configuration register: two selects of 2*ROLength bits.
  function automatic int unsigned cfg_w(input int unsigned ro_len);
    return 4 * ro_len;
  endfunction

  // Score must hold 0..W inclusive, W = 2**samples_log.
  function automatic int unsigned score_w(input int unsigned samples_log);
    return samples_log + 1;
  endfunction

endpackage

// File: rtl/matching_controller_scan_if.sv
// Sampler handshake, runtime configuration and status of the matching controller.
interface matching_controller_scan_if
  import matching_pkg::*;
#(
  parameter int unsigned CSCntLength  = 16,
  parameter int unsigned NBCheckbits  = 10,
  parameter int unsigned ROLength     = 3,
  parameter int unsigned NBSamplesLog = 7
);
  logic [CSCntLength-1:0]           CSCnt;
  logic                             CSReq;
  logic                             CSAck;
  logic [NBCheckbits-1:0]           threshL;
  logic [NBCheckbits-1:0]           threshH;
  logic [score_w(NBSamplesLog)-1:0] samplesMin;
  logic                             modeBest;
  logic                             restart;
  logic [2*ROLength-1:0]            RO0Sel;
  logic [2*ROLength-1:0]            RO1Sel;
  logic                             matched;
  logic                             noFound;
  logic                             locked;
  logic [score_w(NBSamplesLog)-1:0] bestScore;

  modport slave (
    input  CSCnt, CSReq, threshL, threshH, samplesMin, modeBest, restart,
    output CSAck, RO0Sel, RO1Sel, matched, noFound, locked, bestScore
  );

  modport master (
    output CSCnt, CSReq, threshL, threshH, samplesMin, modeBest, restart,
    input  CSAck, RO0Sel, RO1Sel, matched, noFound, locked, bestScore
  );
endinterface

// File: rtl/cs_window_scorer.sv
// Accepts coherent-sampler counts, discards settle samples after a clear and
// scores in-window samples over windows of 2**NBSamplesLog scored samples.
module cs_window_scorer
  import matching_pkg::*;
#(
  parameter int unsigned CSCntLength   = 16,
  parameter int unsigned NBCheckbits   = 10,
  parameter int unsigned NBSamplesLog  = 7,
  parameter int unsigned SettleSamples = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CSCntLength-1:0]           cs_cnt_i,
  input  logic                             cs_req_i,
  input  logic [NBCheckbits-1:0]           thresh_l_i,
  input  logic [NBCheckbits-1:0]           thresh_h_i,
  input  logic                             clear_i,
  output logic                             cs_ack_o,
  output logic                             accept_o,
  output logic                             win_close_o,
  output logic [score_w(NBSamplesLog)-1:0] score_o
);
  localparam int unsigned SW = score_w(NBSamplesLog);

  logic                    ack_q;
  logic [NBSamplesLog-1:0] settle_q, settle_d;
  logic [NBSamplesLog-1:0] cnt_q, cnt_d;
  logic [SW-1:0]           score_q, score_d, score_new;
  logic [NBCheckbits-1:0]  top_bits;
  logic                    good, accept, scored;
  logic                    unused_cnt_bits;

  assign unused_cnt_bits = ^cs_cnt_i;
  assign top_bits        = cs_cnt_i[CSCntLength-1 -: NBCheckbits];
  assign good            = (top_bits >= thresh_l_i) && (top_bits < thresh_h_i);
  assign accept          = cs_req_i && !ack_q;
  assign scored          = accept && (settle_q == '0);
  assign score_new       = score_q + SW'(good);

  assign cs_ack_o    = ack_q;
  assign accept_o    = accept;
  assign win_close_o = scored && (&cnt_q);
  assign score_o     = score_new;

  // Settle countdown, window sample count and running score.
  always_comb begin
    settle_d = settle_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    if (clear_i) begin
      settle_d = NBSamplesLog'(SettleSamples);
      cnt_d    = '0;
      score_d  = '0;
    end else if (accept) begin
      if (settle_q != '0) begin
        settle_d = settle_q - NBSamplesLog'(1);
      end else if (&cnt_q) begin
        cnt_d   = '0;
        score_d = '0;
      end else begin
        cnt_d   = cnt_q + NBSamplesLog'(1);
        score_d = score_new;
      end
    end
  end

  // Acknowledge register and scorer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      settle_q <= NBSamplesLog'(SettleSamples);
      cnt_q    <= '0;
      score_q  <= '0;
    end else begin
      ack_q    <= accept;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
    end
  end

endmodule

// File: rtl/matching_controller_scan.sv
// RO configuration controller for a COSO TRNG: first-fit search or best-fit
// scan for a configuration whose sampler counts fall inside a window, with
// miss hysteresis while matched and a lock watchdog.
module matching_controller_scan
  import matching_pkg::*;
#(
  parameter int unsigned CSCntLength   = 16,
  parameter int unsigned NBCheckbits   = 10,
  parameter int unsigned ROLength      = 3,
  parameter int unsigned NBSamplesLog  = 7,
  parameter int unsigned SettleSamples = 2,
  parameter int unsigned DropShift     = 4,
  parameter int unsigned MaxMiss       = 2,
  parameter int unsigned MaxLockCntLog = 8
) (
  input logic                       clk,
  input logic                       rst,
  matching_controller_scan_if.slave bus
);
  localparam int unsigned CFG_W = cfg_w(ROLength);
  localparam int unsigned SW    = score_w(NBSamplesLog);
  localparam int unsigned MW    = $clog2(MaxMiss + 1);

  state_e                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [CFG_W-1:0]         cfg_q, cfg_d, best_cfg_q, best_cfg_d;
  logic [SW-1:0]            best_q, best_d, best_score_q, best_score_d;
  logic [MW-1:0]            miss_q, miss_d, miss_inc;
  logic [MaxLockCntLog-1:0] lock_q, lock_d;
  logic                     matched_q, matched_d;
  logic                     no_found_q, no_found_d;
  logic                     locked_q, locked_d;

  logic             accept, win_close, win_clear, force_clear, wd_exp, cfg_last;
  logic [SW-1:0]    score, scan_score, scan_best, miss_floor;
  logic [CFG_W-1:0] scan_best_cfg;

  cs_window_scorer #(
    .CSCntLength  (CSCntLength),
    .NBCheckbits  (NBCheckbits),
    .NBSamplesLog (NBSamplesLog),
    .SettleSamples(SettleSamples)
  ) u_scorer (
    .clk        (clk),
    .rst        (rst),
    .cs_cnt_i   (bus.CSCnt),
    .cs_req_i   (bus.CSReq),
    .thresh_l_i (bus.threshL),
    .thresh_h_i (bus.threshH),
    .clear_i    (win_clear),
    .cs_ack_o   (bus.CSAck),
    .accept_o   (accept),
    .win_close_o(win_close),
    .score_o    (score)
  );

  assign wd_exp        = &lock_q;
  assign cfg_last      = &cfg_q;
  assign miss_floor    = bus.samplesMin >> DropShift;
  assign miss_inc      = miss_q + MW'(1);
  // A watchdog expiry during a scan scores the current cfg as zero.
  assign scan_score    = wd_exp ? '0 : score;
  assign scan_best     = (scan_score > best_q) ? scan_score : best_q;
  assign scan_best_cfg = (scan_score > best_q) ? cfg_q : best_cfg_q;
  // Any cfg change discards the open window and reloads settle.
  assign win_clear     = force_clear || (cfg_d != cfg_q);

  assign bus.RO0Sel    = cfg_q[2*ROLength-1:0];
  assign bus.RO1Sel    = cfg_q[CFG_W-1:2*ROLength];
  assign bus.matched   = matched_q;
  assign bus.noFound   = no_found_q;
  assign bus.locked    = locked_q;
  assign bus.bestScore = best_score_q;

  // Next-state logic: restart over watchdog over window close.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cfg_d        = cfg_q;
    best_cfg_d   = best_cfg_q;
    best_d       = best_q;
    best_score_d = best_score_q;
    miss_d       = miss_q;
    matched_d    = matched_q;
    no_found_d   = no_found_q;
    locked_d     = accept ? 1'b0 : locked_q;
    lock_d       = accept ? '0 : lock_q + MaxLockCntLog'(1);
    force_clear  = 1'b0;

    if (bus.restart) begin
      state_d      = bus.modeBest ? SCAN : SEARCH;
      mode_d       = bus.modeBest;
      cfg_d        = '0;
      best_cfg_d   = '0;
      best_d       = '0;
      best_score_d = '0;
      miss_d       = '0;
      matched_d    = 1'b0;
      no_found_d   = 1'b0;
      locked_d     = 1'b0;
      lock_d       = '0;
      force_clear  = 1'b1;
    end else begin
      if (wd_exp) begin
        locked_d    = 1'b1;
        force_clear = 1'b1;
      end
      if ((state_q == SCAN) && (wd_exp || win_close)) begin
        best_d       = scan_best;
        best_cfg_d   = scan_best_cfg;
        best_score_d = scan_best;
        force_clear  = 1'b1;
        if (cfg_last) begin
          if (scan_best >= bus.samplesMin) begin
            cfg_d     = scan_best_cfg;
            state_d   = MATCHED;
            matched_d = 1'b1;
            miss_d    = '0;
          end else begin
            state_d    = FAIL;
            no_found_d = 1'b1;
          end
        end else begin
          cfg_d = cfg_q + CFG_W'(1);
        end
      end else if (wd_exp) begin
        if (state_q != FAIL) begin
          matched_d = 1'b0;
          miss_d    = '0;
          if (cfg_last) begin
            state_d    = FAIL;
            no_found_d = 1'b1;
          end else begin
            cfg_d   = cfg_q + CFG_W'(1);
            state_d = SEARCH;
          end
        end
      end else if (win_close) begin
        best_score_d = score;
        case (state_q)
          SEARCH: begin
            if (score >= bus.samplesMin) begin
              state_d   = MATCHED;
              matched_d = 1'b1;
              miss_d    = '0;
            end else if (cfg_last) begin
              state_d    = FAIL;
              no_found_d = 1'b1;
            end else begin
              cfg_d = cfg_q + CFG_W'(1);
            end
          end
          MATCHED: begin
            if (score < miss_floor) begin
              if (miss_inc == MW'(MaxMiss)) begin
                matched_d   = 1'b0;
                miss_d      = '0;
                force_clear = 1'b1;
                if (mode_q) begin
                  cfg_d      = '0;
                  best_d     = '0;
                  best_cfg_d = '0;
                  state_d    = SCAN;
                end else begin
                  cfg_d   = cfg_q + CFG_W'(1);
                  state_d = SEARCH;
                end
              end else begin
                miss_d = miss_inc;
              end
            end else begin
              miss_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Controller state registers; reset samples modeBest to pick the start state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= bus.modeBest ? SCAN : SEARCH;
      mode_q       <= bus.modeBest;
      cfg_q        <= '0;
      best_cfg_q   <= '0;
      best_q       <= '0;
      best_score_q <= '0;
      miss_q       <= '0;
      lock_q       <= '0;
      matched_q    <= 1'b0;
      no_found_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cfg_q        <= cfg_d;
      best_cfg_q   <= best_cfg_d;
      best_q       <= best_d;
      best_score_q <= best_score_d;
      miss_q       <= miss_d;
      lock_q       <= lock_d;
      matched_q    <= matched_d;
      no_found_q   <= no_found_d;
      locked_q     <= locked_d;
    end
  end

endmodule

// File: doc/matching_controller_scan.md
Name: matching_controller_scan

Overview:
- Successor controller for a coherent-sampler TRNG (COSO). Drives RO0Sel/RO1Sel, the ring-oscillator configuration, so that coherent-sampler counts fall inside a runtime-programmable window.
- Adds a best-fit scan mode, a settle discard after every reconfiguration, miss-count hysteresis while matched, and a restart input. Keeps the first-fit search mode.
- Sits between the coherent sampler (CSCnt/CSReq/CSAck) and the RO configuration inputs.

Parameters:
- CSCntLength, 16, coherent sampler counter width.
- NBCheckbits, 10, MSBs of CSCnt compared against thresholds.
- ROLength, 3, RO length; config register CFG_W = 4*ROLength bits.
- NBSamplesLog, 7, window W = 2^NBSamplesLog accepted samples; score width NBSamplesLog+1.
- SettleSamples, 2, samples acked but not scored after each config change (0..W-1).
- DropShift, 4, matched-monitor floor = samplesMin>>DropShift.
- MaxMiss, 2, consecutive below-floor windows before match is dropped (>=1).
- MaxLockCntLog, 8, lock watchdog counter width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- CSCnt, in, CSCntLength, coherent sampler count.
- CSReq, in, 1, count valid.
- threshL, in, NBCheckbits, lower bound (inclusive).
- threshH, in, NBCheckbits, upper bound (exclusive).
- samplesMin, in, NBSamplesLog+1, match criterion score.
- modeBest, in, 1, 0 = first-fit, 1 = best-fit scan; sampled on restart/reset exit.
- restart, in, 1, pulse: abort and restart search from config 0.
- RO0Sel, out, 2*ROLength, config bits [2*ROLength-1:0].
- RO1Sel, out, 2*ROLength, config bits [CFG_W-1:2*ROLength].
- CSAck, out, 1, one-cycle acknowledge.
- matched, out, 1, good configuration active.
- noFound, out, 1, search exhausted (sticky).
- locked, out, 1, watchdog expired; cleared on next accepted sample.
- bestScore, out, NBSamplesLog+1, score of the last completed window (best-fit: best score found so far).

Behaviour:
- Reset: cfg=0, all outputs 0, state SEARCH (modeBest=0) or SCAN (modeBest=1), counters 0, settle counter = SettleSamples.
- Accept: a sample is accepted when CSReq=1 and CSAck=0. CSAck=1 the next cycle, for exactly one cycle. Holding CSReq high yields one accept per two cycles.
- Good sample: CSCnt[CSCntLength-1 -: NBCheckbits] >= threshL and < threshH, unsigned. threshL >= threshH means no sample is ever good.
- Settle: the first SettleSamples accepts after any cfg change or restart are acked only; they do not touch score or window count.
- Window: closes on the W-th scored sample. The decision uses the final score including that sample. Score and count clear in the same cycle.
- SEARCH: on close, score >= samplesMin -> MATCHED, matched=1. Otherwise cfg+1. If cfg was all-ones, go FAIL with noFound=1 and hold cfg.
- SCAN: on close, score > best -> best=score, bestCfg=cfg (strict compare, so ties keep the lower cfg). Then cfg+1. After the all-ones cfg closes: best >= samplesMin -> cfg=bestCfg, MATCHED. Otherwise FAIL, noFound=1.
- MATCHED, on close:
  - score < samplesMin>>DropShift -> missCnt+1.
  - score >= that floor -> missCnt=0.
  - missCnt reaching MaxMiss -> matched=0, then first-fit: cfg+1 into SEARCH; best-fit: cfg=0, best=0 into SCAN.
- FAIL: cfg held, samples still acked, exits only via rst or restart.
- Watchdog: lockCnt increments every cycle with no accept and clears on accept. At all-ones: locked=1, open window discarded, settle reloaded, and:
  - SEARCH/MATCHED: matched=0, cfg+1 into SEARCH (wrap -> FAIL).
  - SCAN: that cfg scores 0 and the scan advances.
  - FAIL: no action.
- Every cfg change reloads settle and clears the window.
- Simultaneous events: restart beats watchdog, watchdog beats window close, rst beats all.
- restart: same as reset except threshold inputs are not affected.
- Decision latency: outputs update 1 cycle after the closing accept.

Decomposition:
- Package matching_pkg: state enum {SEARCH, SCAN, MATCHED, FAIL}, CFG_W and score-width helper functions.
- Sub-module cs_window_scorer: accept/ack logic, settle counter, threshold compare, sample and score counters; emits winClose plus score. The FSM, cfg/best registers and watchdog stay in the top.

Test Plan (bench: ROLength=1, NBSamplesLog=3, SettleSamples=2, MaxLockCntLog=5, DropShift=1, MaxMiss=2, samplesMin=6, threshL=0x100, threshH=0x200):
- First-fit: cfg0..2 fed 10 in-range-fail samples each, cfg3 fed 2 discard + 8 good samples -> matched=1 with RO0Sel=3, RO1Sel=0; CSAck count equals CSReq accepts.
- Best-fit: scores 3,7,7,5 on cfg 0..3, <=2 on the rest -> after cfg 15, cfg=1, matched=1, bestScore=7.
- Exhaustion: all samples out of range in first-fit -> after cfg 15 closes, noFound=1, cfg stays 15, later CSReq still acked.
- Hysteresis: matched at cfg 5, then windows scoring 2, 4, 2, 2 -> matched drops only after the fourth window, cfg becomes 6.
- Watchdog: matched, CSReq idle 31 cycles -> locked=1, matched=0, cfg+1; next accept clears locked.
- Boundaries: count top bits = 0x0FF, 0x100, 0x1FF, 0x200 -> only 0x100 and 0x1FF score; restart coinciding with watchdog expiry -> cfg=0, locked=0.
